// File: rtl/lau_pkg.sv
// Shared definitions for the load alignment path: size encodings,
// FSM state encoding and the access-size helper.
package lau_pkg;

    // Load size encodings, identical to the existing truncate-and-extend encoding
    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10,
        RSP  = 2'b11
    } lau_state_t;

    // Number of bytes an access touches; a doubleword falls back to a word on 32-bit datapaths
    function automatic logic [3:0] size_to_bytes(input logic [1:0] size, input int data_w);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_D:    return (data_w == 64) ? 4'd8 : 4'd4;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/lau_extend.sv
// Combinational truncate-and-extend: keeps the low 8n bits of an already
// shifted window and fills the upper bits with zeros or the sign bit.
module lau_extend
    import lau_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] window,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [DATA_W-1:0] result
);

    logic [6:0]        nbits;
    logic [DATA_W-1:0] keep_mask;
    logic              msb;

    // Build a keep mask from the access width, pick the sign bit, then merge
    always_comb begin
        nbits     = {size_to_bytes(size, DATA_W), 3'b000};
        keep_mask = ~({DATA_W{1'b1}} << nbits);
        case (size)
            SZ_B:    msb = window[7];
            SZ_H:    msb = window[15];
            SZ_D:    msb = window[DATA_W-1];
            default: msb = window[31];
        endcase
        result = (window & keep_mask) | ({DATA_W{sign & msb}} & ~keep_mask);
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path between the memory stage and the data-memory port. Accepts one
// load at a time, issues one or two word reads (two when the access crosses
// a memory-word boundary), splices and extends the data, and returns it.
module load_align_unit
    import lau_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              I_LAU_clk,
    input  logic              I_LAU_rst_n,
    input  logic              I_LAU_req_valid,
    output logic              O_LAU_req_ready,
    input  logic [ADDR_W-1:0] I_LAU_addr,
    input  logic [1:0]        I_LAU_size,
    input  logic              I_LAU_sign,
    output logic              O_LAU_mem_rd,
    output logic [ADDR_W-1:0] O_LAU_mem_addr,
    input  logic              I_LAU_mem_ack,
    input  logic [DATA_W-1:0] I_LAU_mem_data,
    output logic              O_LAU_rsp_valid,
    input  logic              I_LAU_rsp_ready,
    output logic [DATA_W-1:0] O_LAU_result,
    output logic              O_LAU_misaligned
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    lau_state_t state, state_nxt;

    logic [OFF_W-1:0]  off_q, off_nxt;
    logic [1:0]        size_q, size_nxt;
    logic              sign_q, sign_nxt;
    logic [DATA_W-1:0] lo_buf, lo_nxt;

    logic              req_ready_nxt;
    logic              mem_rd_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] result_nxt;
    logic              misaligned_nxt;

    logic [3:0]          nbytes_in;
    logic [3:0]          nbytes_q;
    logic                in_aligned;
    logic [ADDR_W-1:0]   in_word_addr;
    logic [4:0]          end_q;
    logic                cross_q;
    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   window;
    logic [DATA_W-1:0]   ext_result;

    // Address decode for the incoming request and the latched one
    always_comb begin
        nbytes_in    = size_to_bytes(I_LAU_size, DATA_W);
        nbytes_q     = size_to_bytes(size_q, DATA_W);
        in_aligned   = (I_LAU_addr[2:0] & 3'(nbytes_in - 4'd1)) == 3'b000;
        in_word_addr = {I_LAU_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end_q        = 5'(off_q) + 5'(nbytes_q);
        cross_q      = end_q > 5'(BYTES);
    end

    // Splice the returning word (and the low buffer on a second read) and shift the access to bit 0
    always_comb begin
        if (state == RD1) begin
            pair = {I_LAU_mem_data, lo_buf};
        end else begin
            pair = {{DATA_W{1'b0}}, I_LAU_mem_data};
        end
        window = DATA_W'(pair >> {off_q, 3'b000});
    end

    lau_extend #(
        .DATA_W (DATA_W)
    ) u_extend (
        .window (window),
        .size   (size_q),
        .sign   (sign_q),
        .result (ext_result)
    );

    // Next-state and next-output logic; every output is computed here one edge ahead and registered
    always_comb begin
        state_nxt      = state;
        off_nxt        = off_q;
        size_nxt       = size_q;
        sign_nxt       = sign_q;
        lo_nxt         = lo_buf;
        req_ready_nxt  = O_LAU_req_ready;
        mem_rd_nxt     = O_LAU_mem_rd;
        mem_addr_nxt   = O_LAU_mem_addr;
        rsp_valid_nxt  = O_LAU_rsp_valid;
        result_nxt     = O_LAU_result;
        misaligned_nxt = O_LAU_misaligned;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (I_LAU_req_valid && O_LAU_req_ready) begin
                    req_ready_nxt = 1'b0;
                    off_nxt       = I_LAU_addr[OFF_W-1:0];
                    size_nxt      = I_LAU_size;
                    sign_nxt      = I_LAU_sign;
                    if (!MISALIGN_EN && !in_aligned) begin
                        state_nxt      = RSP;
                        rsp_valid_nxt  = 1'b1;
                        result_nxt     = '0;
                        misaligned_nxt = 1'b1;
                    end else begin
                        state_nxt    = RD0;
                        mem_rd_nxt   = 1'b1;
                        mem_addr_nxt = in_word_addr;
                    end
                end
            end
            RD0: begin
                if (I_LAU_mem_ack) begin
                    lo_nxt = I_LAU_mem_data;
                    if (cross_q) begin
                        state_nxt    = RD1;
                        mem_addr_nxt = O_LAU_mem_addr + ADDR_W'(BYTES);
                    end else begin
                        state_nxt      = RSP;
                        mem_rd_nxt     = 1'b0;
                        rsp_valid_nxt  = 1'b1;
                        result_nxt     = ext_result;
                        misaligned_nxt = 1'b0;
                    end
                end
            end
            RD1: begin
                if (I_LAU_mem_ack) begin
                    state_nxt      = RSP;
                    mem_rd_nxt     = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    result_nxt     = ext_result;
                    misaligned_nxt = 1'b0;
                end
            end
            RSP: begin
                if (I_LAU_rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge I_LAU_clk or negedge I_LAU_rst_n) begin
        if (!I_LAU_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, low buffer and registered outputs
    always_ff @(posedge I_LAU_clk or negedge I_LAU_rst_n) begin
        if (!I_LAU_rst_n) begin
            off_q            <= '0;
            size_q           <= SZ_W;
            sign_q           <= 1'b0;
            lo_buf           <= '0;
            O_LAU_req_ready  <= 1'b0;
            O_LAU_mem_rd     <= 1'b0;
            O_LAU_mem_addr   <= '0;
            O_LAU_rsp_valid  <= 1'b0;
            O_LAU_result     <= '0;
            O_LAU_misaligned <= 1'b0;
        end else begin
            off_q            <= off_nxt;
            size_q           <= size_nxt;
            sign_q           <= sign_nxt;
            lo_buf           <= lo_nxt;
            O_LAU_req_ready  <= req_ready_nxt;
            O_LAU_mem_rd     <= mem_rd_nxt;
            O_LAU_mem_addr   <= mem_addr_nxt;
            O_LAU_rsp_valid  <= rsp_valid_nxt;
            O_LAU_result     <= result_nxt;
            O_LAU_misaligned <= misaligned_nxt;
        end
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load path between the core's memory stage and the data-memory port. It generalises the word/half/byte truncate-and-extend step to a configurable data width and adds a doubleword size. It also handles accesses that cross a memory-word boundary, fetching two words and splicing them. All of this runs through a small request/response FSM with valid/ready handshakes on the core side and a read/ack port on the memory side.

## Interface
- DATA_W, 32: memory word and result width; 32 or 64 only.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing loads into two reads; 0 = flag misaligned loads as faults.
- I_LAU_clk  in  1  clock; all state changes on the rising edge.
- I_LAU_rst_n  in  1  asynchronous, active-low reset.
- I_LAU_req_valid  in  1  load request present.
- O_LAU_req_ready  out  1  unit can accept a request.
- I_LAU_addr  in  ADDR_W  byte address of load.
- I_LAU_size  in  2  00 = W, 01 = H, 10 = B, 11 = D (D only when DATA_W=64; otherwise treated as W).
- I_LAU_sign  in  1  1 = sign-extend, 0 = zero-extend.
- O_LAU_mem_rd  out  1  memory read strobe.
- O_LAU_mem_addr  out  ADDR_W  word-aligned read address.
- I_LAU_mem_ack  in  1  read data valid this cycle.
- I_LAU_mem_data  in  DATA_W  read data, little-endian.
- O_LAU_rsp_valid  out  1  result valid.
- I_LAU_rsp_ready  in  1  consumer takes result.
- O_LAU_result  out  DATA_W  extended load result.
- O_LAU_misaligned  out  1  fault flag, qualified by rsp_valid.

## Operation
- Definitions:
  - BYTES = DATA_W/8.
  - off = addr[log2(BYTES)-1:0].
  - n = 1/2/4/8 bytes for B/H/W/D.
  - cross = (off + n > BYTES).
  - aligned = (addr mod n == 0).
- FSM states: IDLE, RD0, RD1, RSP.
- IDLE:
  - req_ready=1.
  - On valid&&ready, latch addr, size and sign.
  - If MISALIGN_EN=0 and !aligned, go to RSP with result=0 and misaligned=1. No memory read is issued.
  - Otherwise go to RD0.
- RD0:
  - mem_rd=1, mem_addr = addr with the low log2(BYTES) bits cleared.
  - On ack, capture data into the low buffer.
  - Then go to RD1 if cross, else RSP.
- RD1:
  - mem_rd=1, mem_addr = aligned address + BYTES, wrapping mod 2^ADDR_W.
  - On ack, capture data into the high buffer and go to RSP.
- Splice: window = {hi,lo} >> (8*off). Take the low 8n bits and extend to DATA_W per sign. When !cross, hi is ignored.
- RSP:
  - rsp_valid=1; result and misaligned are held stable.
  - On rsp_ready, go to IDLE.
- mem_ack is ignored in IDLE and RSP.
- mem_rd and mem_addr stay constant until ack (no withdrawal).

## Timing
- All outputs are registered.
- Reset values:
  - req_ready=0, then 1 from the first edge after release.
  - mem_rd=0, mem_addr=0, rsp_valid=0, result=0, misaligned=0, state=IDLE.
- Zero-wait memory (ack in the same cycle as mem_rd), counting from the acceptance edge:
  - Non-crossing load: rsp_valid after 2 edges.
  - Crossing load: rsp_valid after 3 edges.
  - Fault: rsp_valid after 1 edge.
- Each cycle of ack delay adds one cycle of latency.
- req_ready drops on the acceptance edge. It returns on the edge that completes the rsp handshake; back-to-back issue resumes the following cycle.
- Asserting rst_n low in any state abandons the operation immediately: no response, and outputs go to reset values asynchronously.

## Structure
- Package lau_pkg holds:
  - Size encodings SZ_W/SZ_H/SZ_B/SZ_D, kept identical to the existing truncate encoding.
  - FSM state encoding.
  - Function size_to_bytes.
- Sub-module lau_extend: combinational, DATA_W-parametrised. Maps a window, size and sign to the extended result, and is reusable by other load paths.
- The top level holds the FSM, the address latch, the lo/hi buffers and the output registers.

## Test plan
All scenarios use DATA_W=32 unless noted.
- B, signed, addr 0x1003, mem[0x1000]=0x80FF1234 -> one read at 0x1000, result 0xFFFFFF80, rsp_valid 2 edges after accept.
- H, unsigned, addr 0x2002, mem[0x2000]=0xBEEF0000 -> result 0x0000BEEF, misaligned=0.
- W, addr 0x3003, mem[0x3000]=0x44332211, mem[0x3004]=0x88776655 -> reads at 0x3000 then 0x3004, result 0x77665544, rsp 3 edges after accept.
- MISALIGN_EN=0, H, addr 0x3001 -> no mem_rd, misaligned=1, result 0, rsp 1 edge after accept.
- Ack delayed 3 cycles and rsp_ready low 4 cycles:
  - mem_addr stays stable while waiting for ack.
  - result stays stable while rsp_ready is low.
  - req_ready=0 until the rsp handshake.
- Reset mid-operation, then a D load:
  - rst_n low during RD1 -> all outputs 0 immediately; a following B load is served correctly.
  - DATA_W=64, D, addr 0x10, mem=0x8877665544332211 -> result 0x8877665544332211.
